// File: rtl/count_arb_pkg.sv
// Shared definitions for the count_arbiter block: FSM encoding, default sizes,
// and the round-robin index helper.
package count_arb_pkg;

    localparam int unsigned DefNreq  = 4;
    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefLenW  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    // Next index in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/ctr_core.sv
// Shared WIDTH-bit synchronous up-counter; advances by one whenever EN is high.
module ctr_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Increment modulo 2^WIDTH; rollover needs no special handling.
    always_comb begin
        cnt_d = cnt_q;
        if (EN) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/count_arbiter.sv
// Round-robin owner of the shared counter enable. Each selected requester gets
// exactly len[owner] increments, then a one-cycle done pulse, then priority rotates.
// Optional feature macro: CNT_ARB_WRAP_EN adds the wrap output.
module count_arbiter
    import count_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned LEN_W = DefLenW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_en,
    output logic [WIDTH-1:0]      Q
`ifdef CNT_ARB_WRAP_EN
    ,
    output logic                  wrap
`endif
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    logic [LEN_W-1:0]  len_arr [NREQ];
    logic              sel_found;
    logic [IdxW-1:0]   sel_idx;
    int unsigned       cand;
    logic [NREQ-1:0]   owner_oh;

    for (genvar g = 0; g < NREQ; g++) begin : g_len
        assign len_arr[g] = len[g*LEN_W +: LEN_W];
    end

    // First asserted request at or after ptr, walking upward around the ring.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 32'(ptr_q);
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!sel_found && req[IdxW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(cand);
            end
            cand = rr_next(cand, NREQ);
        end
    end

    // Next-state logic: commit a burst in IDLE, count it down in RUN, rotate in DONE.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    owner_d = sel_idx;
                    rem_d   = len_arr[sel_idx];
                    // A zero-length burst skips RUN entirely but still reports done.
                    state_d = (len_arr[sel_idx] != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ptr_d   = IdxW'(rr_next(32'(owner_q), NREQ));
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Arbiter state registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
        end
    end

    assign owner_oh = NREQ'(1) << owner_q;

    // Outputs decode only registered state, so req/len never reach them combinationally.
    always_comb begin
        gnt    = '0;
        busy   = (state_q != StIdle);
        cnt_en = (state_q == StRun);
        if (state_q == StRun) begin
            gnt = owner_oh;
        end
    end

`ifdef CNT_ARB_WRAP_EN
    logic wrap_q, wrap_d;

    // Counter rolls over on the coming edge when enabled at all-ones.
    always_comb begin
        wrap_d = cnt_en & (&Q);
    end

    // One-cycle wrap pulse, cleared by reset and never held across bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

    // Done pulse to the owner; a wrap only shows on done when it lands in DONE.
    always_comb begin
        done = '0;
        if (state_q == StDone) begin
            done = owner_oh;
        end
`ifdef CNT_ARB_WRAP_EN
        if (wrap_q && (state_q == StDone)) begin
            done = done | owner_oh;
        end
`endif
    end

    ctr_core #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk (clk),
        .rst (rst),
        .EN  (cnt_en),
        .Q   (Q)
    );

endmodule

// File: tb/tb_count_arbiter.sv
// Directed self-checking bench for count_arbiter (NREQ=4, WIDTH=4, LEN_W=4).
module tb_count_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        cnt_en;
    logic [3:0]  Q;
`ifdef CNT_ARB_WRAP_EN
    logic        wrap;
`endif

    int errors = 0;
    int checks = 0;

    count_arbiter #(
        .NREQ  (4),
        .WIDTH (4),
        .LEN_W (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len    (len),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_en (cnt_en),
        .Q      (Q)
`ifdef CNT_ARB_WRAP_EN
        ,
        .wrap   (wrap)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        len = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        len = 16'h0000;
        tick();
        tick();
        checks++;
        if ({gnt, done, busy, cnt_en, Q} !== {4'b0, 4'b0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b cnt_en=%b Q=%0d, want all 0",
                     gnt, done, busy, cnt_en, Q);
        end
`ifdef CNT_ARB_WRAP_EN
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b want 0", wrap);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 4'b0001;
        len = 16'h0003;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({gnt, cnt_en, busy, done, Q} !== {4'b0001, 1'b1, 1'b1, 4'b0000, 4'(i)}) begin
                errors++;
                $display("FAIL single_run%0d: got gnt=%b en=%b busy=%b done=%b Q=%0d want 0001 1 1 0000 %0d",
                         i, gnt, cnt_en, busy, done, Q, i);
            end
            tick();
        end
        checks++;
        if ({gnt, cnt_en, done, Q} !== {4'b0000, 1'b0, 4'b0001, 4'd3}) begin
            errors++;
            $display("FAIL single_done: got gnt=%b en=%b done=%b Q=%0d want 0000 0 0001 3",
                     gnt, cnt_en, done, Q);
        end
        tick();
        checks++;
        if ({busy, done, Q} !== {1'b0, 4'b0000, 4'd3}) begin
            errors++;
            $display("FAIL single_idle: got busy=%b done=%b Q=%0d want 0 0000 3", busy, done, Q);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_oh;
        do_reset();
        req = 4'b1111;
        len = 16'h1111;
        for (int g = 0; g < 5; g++) begin
            exp_oh = 4'b0001 << (g % 4);
            tick();
            checks++;
            if ({gnt, cnt_en} !== {exp_oh, 1'b1}) begin
                errors++;
                $display("FAIL rr_gnt%0d: got gnt=%b en=%b want %b 1", g, gnt, cnt_en, exp_oh);
            end
            tick();
            checks++;
            if ({done, gnt} !== {exp_oh, 4'b0000}) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%b gnt=%b want %b 0000", g, done, gnt, exp_oh);
            end
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle%0d: got busy=%b want 0", g, busy);
            end
        end
        req = 4'b0000;
        checks++;
        if (Q !== 4'd5) begin
            errors++;
            $display("FAIL rr_final_q: got %0d want 5", Q);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_q;
        do_reset();
        // Owner 0 counts Q up to 14, leaving ptr at 1.
        req = 4'b0001;
        len = 16'h000E;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if ({done, Q} !== {4'b0001, 4'd14}) begin
            errors++;
            $display("FAIL wrap_setup: got done=%b Q=%0d want 0001 14", done, Q);
        end
        tick();
        req = 4'b0100;
        len = 16'h0400;
        tick();
        req = 4'b0000;
        checks++;
        if ({gnt, Q} !== {4'b0100, 4'd14}) begin
            errors++;
            $display("FAIL wrap_start: got gnt=%b Q=%0d want 0100 14", gnt, Q);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_q = 4'(15 + i);
            checks++;
            if (Q !== exp_q) begin
                errors++;
                $display("FAIL wrap_q%0d: got %0d want %0d", i, Q, exp_q);
            end
`ifdef CNT_ARB_WRAP_EN
            checks++;
            if (wrap !== (i == 1)) begin
                errors++;
                $display("FAIL wrap_pulse%0d: got %b want %b", i, wrap, (i == 1));
            end
`endif
        end
        checks++;
        if ({done, gnt} !== {4'b0100, 4'b0000}) begin
            errors++;
            $display("FAIL wrap_done: got done=%b gnt=%b want 0100 0000", done, gnt);
        end
        tick();
    endtask

    task automatic test_zero_len();
        // ptr is 3 here; search 3,0,1 lands on requester 1. Q is 2 from the wrap burst.
        req = 4'b0010;
        len = 16'h0000;
        tick();
        req = 4'b0000;
        checks++;
        if ({done, gnt, cnt_en, busy, Q} !== {4'b0010, 4'b0000, 1'b0, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL zero_done: got done=%b gnt=%b en=%b busy=%b Q=%0d want 0010 0000 0 1 2",
                     done, gnt, cnt_en, busy, Q);
        end
        tick();
        checks++;
        if ({done, gnt, busy, Q} !== {4'b0000, 4'b0000, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL zero_idle: got done=%b gnt=%b busy=%b Q=%0d want 0000 0000 0 2",
                     done, gnt, busy, Q);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0001;
        len = 16'h0005;
        tick();
        // Dropping req and changing len after selection must not disturb the burst.
        req = 4'b0000;
        len = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({gnt, cnt_en} !== {4'b0001, 1'b1}) begin
                errors++;
                $display("FAIL drop_run%0d: got gnt=%b en=%b want 0001 1", i, gnt, cnt_en);
            end
            tick();
        end
        checks++;
        if ({done, gnt, Q} !== {4'b0001, 4'b0000, 4'd5}) begin
            errors++;
            $display("FAIL drop_done: got done=%b gnt=%b Q=%0d want 0001 0000 5", done, gnt, Q);
        end
        len = 16'h0000;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        // Owner 0 runs once so ptr moves to 1.
        req = 4'b0001;
        len = 16'h0001;
        tick();
        tick();
        tick();
        req = 4'b0010;
        len = 16'h0060;
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if ({gnt, Q} !== {4'b0010, 4'd2}) begin
            errors++;
            $display("FAIL mid_run2: got gnt=%b Q=%0d want 0010 2", gnt, Q);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({Q, gnt, done, busy, cnt_en} !== {4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_abort: got Q=%0d gnt=%b done=%b busy=%b en=%b want 0 0000 0000 0 0",
                     Q, gnt, done, busy, cnt_en);
        end
        tick();
        checks++;
        if ({done, busy} !== {4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL mid_no_done: got done=%b busy=%b want 0000 0", done, busy);
        end
        // With ptr back at 0, requester 0 wins over requester 1.
        req = 4'b0011;
        len = 16'h0011;
        tick();
        req = 4'b0000;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_reset: got gnt=%b want 0001", gnt);
        end
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        len = 16'h0000;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_zero_len();
        test_drop();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
